// File: rtl/rfft_pkg.sv
// Shared definitions for the 256-point RFFT working-memory readers/writers.
//   RFFT_WIDTH  : bank word width
//   RFFT_N      : transform length (4 banks of RFFT_N/4 words)
//   RFFT_LOG2N  : log2 of the transform length, i.e. sequence index width
//   NBANK       : number of interleaved banks
//   BANK_AW     : per-bank address width
//   state_t     : unloader FSM encoding
//   bitreverse(): index permutation used for bit-reversed emission order
package rfft_pkg;

  localparam int RFFT_WIDTH = 32;
  localparam int RFFT_N     = 256;
  localparam int RFFT_LOG2N = 8;
  localparam int NBANK      = 4;
  localparam int BANK_AW    = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  function automatic logic [RFFT_LOG2N-1:0] bitreverse(input logic [RFFT_LOG2N-1:0] v);
    logic [RFFT_LOG2N-1:0] r;
    for (int i = 0; i < RFFT_LOG2N; i++) r[i] = v[RFFT_LOG2N-1-i];
    return r;
  endfunction

endpackage

// File: rtl/rfft_unloader_if.sv
// Bus bundle of the RFFT unloader: the shared bank read port on one side and
// the valid/ready result stream on the other.
//   master : the unloader (drives bank reads and the stream)
//   slave  : its environment (banks return data, consumer drives ready)
//   rd_en / rd_addr       : bank read request, common to all four banks
//   rd_data0..rd_data3    : bank outputs, one cycle after the request
//   m_data/m_index/m_last : stream beat payload
//   m_valid / m_ready     : stream handshake
interface rfft_unloader_if
  import rfft_pkg::*;
#(
  parameter int WIDTH = RFFT_WIDTH,
  parameter int LOG2N = RFFT_LOG2N,
  parameter int AW    = BANK_AW
);

  logic             rd_en;
  logic [AW-1:0]    rd_addr;
  logic [WIDTH-1:0] rd_data0;
  logic [WIDTH-1:0] rd_data1;
  logic [WIDTH-1:0] rd_data2;
  logic [WIDTH-1:0] rd_data3;

  logic [WIDTH-1:0] m_data;
  logic [LOG2N-1:0] m_index;
  logic             m_valid;
  logic             m_ready;
  logic             m_last;

  modport master (
    output rd_en, rd_addr, m_data, m_index, m_valid, m_last,
    input  rd_data0, rd_data1, rd_data2, rd_data3, m_ready
  );

  modport slave (
    input  rd_en, rd_addr, m_data, m_index, m_valid, m_last,
    output rd_data0, rd_data1, rd_data2, rd_data3, m_ready
  );

endinterface

// File: rtl/rfft_skid_fifo.sv
// Two-entry first-word-fall-through FIFO of {data, index} pairs. Entry 0 is
// always the head, so the head outputs come straight from a register.
//   Clk, Reset_n           : clock, asynchronous active-low reset
//   push, push_data/index  : write request and payload
//   pop                    : consume the head entry
//   head_data, head_index  : current head entry
//   valid                  : head entry present
//   occupancy              : number of stored entries (0..2)
module rfft_skid_fifo #(
  parameter int WIDTH = 32,
  parameter int IDXW  = 8
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic [IDXW-1:0]  push_index,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic [IDXW-1:0]  head_index,
  output logic             valid,
  output logic [1:0]       occupancy
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic [IDXW-1:0]  index;
  } entry_t;

  entry_t     e0, e1;
  entry_t     in_e;
  logic [1:0] occ;
  logic       do_pop;
  logic       do_push;

  assign in_e    = {push_data, push_index};
  // A pop on an empty FIFO is ignored; a push into a full FIFO is only taken
  // when the head leaves in the same cycle, so nothing is ever overwritten.
  assign do_pop  = pop && (occ != 2'd0);
  assign do_push = push && ((occ != 2'd2) || do_pop);

  // NOTE: the two storage entries are reset along with the count because they
  // drive the stream outputs directly, which must read 0 during reset.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      occ <= 2'd0;
      e0  <= '0;
      e1  <= '0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (occ == 2'd0) e0 <= in_e;
          else             e1 <= in_e;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          e0  <= e1;
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd1) begin
            e0 <= in_e;
          end else begin
            e0 <= e1;
            e1 <= in_e;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_data  = e0.data;
  assign head_index = e0.index;
  assign valid      = (occ != 2'd0);
  assign occupancy  = occ;

endmodule

// File: rtl/rfft_unloader.sv
// Reader side of the 256-point RFFT working memory. On start it reads the four
// interleaved result banks and serialises the N results onto a valid/ready
// stream in natural or bit-reversed order. A 2-entry skid FIFO absorbs the
// one-cycle bank latency and downstream backpressure.
//   Clk, Reset_n : clock, asynchronous active-low reset
//   start        : single-cycle pulse, begin unloading (ignored while busy)
//   busy         : high from start acceptance until the last beat transfers
//   unload_done  : one-cycle pulse after the last beat handshake
//   bus          : bank read port and result stream (master side)
module rfft_unloader
  import rfft_pkg::*;
#(
  parameter int WIDTH  = RFFT_WIDTH,
  parameter int N      = RFFT_N,
  parameter int LOG2N  = RFFT_LOG2N,
  parameter bit BITREV = 1'b1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             start,
  output logic             busy,
  output logic             unload_done,
  rfft_unloader_if.master  bus
);

  localparam int               SELW     = $clog2(NBANK);
  localparam logic [LOG2N:0]   K_END    = (LOG2N+1)'(N);
  localparam logic [LOG2N:0]   K_ONE    = (LOG2N+1)'(1);
  localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

  state_t            state;
  logic [LOG2N:0]    k_rd;        // next sequence number to read; N is terminal
  logic              in_flight;   // a bank read was issued last cycle
  logic [SELW-1:0]   bank_q;      // bank of the in-flight read
  logic [LOG2N-1:0]  k_q;         // sequence number of the in-flight read

  logic [LOG2N-1:0]  k_cur;
  logic [LOG2N-1:0]  j_cur;
  logic              issue;
  logic              pop;
  logic              m_last;
  logic [WIDTH-1:0]  ret_data;

  logic [WIDTH-1:0]  head_data;
  logic [LOG2N-1:0]  head_index;
  logic              head_valid;
  logic [1:0]        occ;

  assign k_cur = k_rd[LOG2N-1:0];
  assign j_cur = BITREV ? bitreverse(k_cur) : k_cur;
  assign pop   = head_valid && bus.m_ready;

  // A read may only be issued if the FIFO can hold its data together with
  // whatever is already stored or on its way, after this cycle's pop.
  assign issue = (state == ST_RUN) && (k_rd < K_END) &&
                 (({1'b0, occ} + {2'b00, in_flight}) < (3'd2 + {2'b00, pop}));

  assign bus.rd_en   = issue;
  assign bus.rd_addr = j_cur[LOG2N-1:SELW];

  // NOTE: every variable assigned here gets a default first so the block
  // stays purely combinational and no latch is inferred.
  always_comb begin
    ret_data = bus.rd_data0;
    case (bank_q)
      2'd1:    ret_data = bus.rd_data1;
      2'd2:    ret_data = bus.rd_data2;
      2'd3:    ret_data = bus.rd_data3;
      default: ;
    endcase
  end

  rfft_skid_fifo #(
    .WIDTH (WIDTH),
    .IDXW  (LOG2N)
  ) u_fifo (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .push       (in_flight),
    .push_data  (ret_data),
    .push_index (k_q),
    .pop        (pop),
    .head_data  (head_data),
    .head_index (head_index),
    .valid      (head_valid),
    .occupancy  (occ)
  );

  assign m_last      = head_valid && (head_index == LAST_IDX);
  assign bus.m_data  = head_data;
  assign bus.m_index = head_index;
  assign bus.m_valid = head_valid;
  assign bus.m_last  = m_last;

  // NOTE: all state below updates with non-blocking assignments so every
  // register samples the pre-edge values of the others, independent of order.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= ST_IDLE;
      k_rd        <= '0;
      in_flight   <= 1'b0;
      bank_q      <= '0;
      k_q         <= '0;
      busy        <= 1'b0;
      unload_done <= 1'b0;
    end else begin
      unload_done <= 1'b0;
      in_flight   <= issue;
      if (issue) begin
        bank_q <= j_cur[SELW-1:0];
        k_q    <= k_cur;
        k_rd   <= k_rd + K_ONE;
      end

      case (state)
        ST_IDLE: begin
          if (start) begin
            state <= ST_RUN;
            k_rd  <= '0;
            busy  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (k_rd == K_END) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop && m_last) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            unload_done <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/rfft_unloader.md
Name: rfft_unloader

Overview:
- Reader side of the 256-point RFFT working memory.
- After the transform finishes, it reads the four 64-deep result banks through their read port and serialises the 256 results onto a valid/ready stream, in natural or bit-reversed order.
- It absorbs the 1-cycle BRAM read latency and downstream backpressure with a 2-entry skid FIFO.
- It sits between the rfft core's banks and the result consumer (DMA/host interface).

Parameters:
WIDTH, 32, data word width (matches bank width)
N, 256, transform length; 4 banks of N/4 words
LOG2N, 8, log2(N); index width
BITREV, 1, 1 = emit bit-reversed index order, 0 = natural order

Ports:
Clk  input  1  clock
Reset_n  input  1  reset; one clock, reset is asynchronous and active-low
start  input  1  single-cycle pulse; begin unloading
busy  output  1  high from start acceptance until the last beat is transferred
rd_en  output  1  bank read enable, shared by all 4 banks
rd_addr  output  6  bank read address, shared by all 4 banks
rd_data0..rd_data3  input  WIDTH each  bank outputs; valid 1 cycle after rd_en/rd_addr are sampled
m_data  output  WIDTH  stream data
m_index  output  LOG2N  output sequence number k of the current beat
m_valid  output  1  stream valid
m_ready  input  1  stream ready
m_last  output  1  high with the beat where k = N-1
unload_done  output  1  one-cycle pulse after the last beat handshake

Behaviour:
- Reset (async assert, sync deassert): FSM = IDLE; counters, FIFO and in-flight flag cleared. All outputs are 0 at reset.
- Index mapping for sequence number k (0..N-1):
  - j = BITREV ? bitreverse(k) : k.
  - Bank = j[1:0]; address = j[7:2].
  - m_data = rd_data[bank] for the beat carrying k.
- FSM states:
  - IDLE: start=1 -> RUN; rd counter k_rd=0, output counter k_out=0, busy=1. start=0 -> remain.
  - RUN: issue reads and drain the FIFO. When k_rd reaches N (all reads issued) -> DRAIN.
  - DRAIN: issue no reads. On the handshake of the beat with k_out = N-1 -> IDLE, busy=0, unload_done=1 for exactly one cycle.
- Read issue rule:
  - rd_en=1 in a cycle only when state=RUN, k_rd<N, and (FIFO occupancy + in_flight - pop) < 2, where pop = m_valid & m_ready.
  - The bank select for each read travels in a 1-cycle pipeline register alongside in_flight.
  - Returned data plus its k are pushed into the FIFO on the next edge.
- Latency:
  - start sampled at edge E0; rd_en=1 during the following cycle.
  - Data captured at E2; m_valid=1 after E2.
- Throughput: with m_ready held at 1, one beat per cycle. The last beat is presented at E0+257; unload_done is high during the cycle after the last handshake.
- Stream rules: while m_valid=1 and m_ready=0, m_data, m_index and m_last hold stable. m_valid never drops without a handshake.
- FIFO full (2 entries) with m_ready=0: rd_en=0; no data is lost or overwritten.
- Push and pop in the same cycle when full is impossible by the issue rule. Push and pop when occupancy=1 keeps occupancy=1.
- start while busy=1: ignored, no restart and no counter change.
- Reset asserted mid-operation: immediate return to IDLE. FIFO is flushed, in-flight data is discarded, and no unload_done is generated.
- Counters are LOG2N+1 bits wide; k_rd=N is the terminal value, with no wrap.

Decomposition:
- Package rfft_pkg: WIDTH, N, LOG2N, NBANK=4, bank address width 6, state encoding (IDLE/RUN/DRAIN), and a bitreverse function.
- One sub-module, rfft_skid_fifo: 2-entry first-word-fall-through FIFO of {WIDTH data, LOG2N index}. It provides push/pop/occupancy and is reusable by the loader.

Test Plan:
- Natural order (BITREV=0), banks preloaded with word = {bank, addr}, m_ready=1, pulse start:
  - k=0..255 appear on consecutive cycles from E0+2.
  - k=5 carries {1, 1}.
  - m_last at k=255.
  - unload_done one cycle after, busy falls.
- Bit-reversed (BITREV=1), same preload:
  - k=1 -> j=128 -> {0, 32}.
  - k=3 -> j=192 -> {0, 48}.
  - All 256 beats are a permutation with no duplicates.
- Backpressure:
  - Drop m_ready for 10 cycles at k=40.
  - rd_en stops within 2 cycles; m_data/m_index are held at k=40.
  - After release, the stream resumes with k=40, 41, ... with no gaps or losses.
  - Random m_ready (50%) over a full run matches the scoreboard.
- start pulsed at k=100 while busy: ignored, and the sequence continues to 255 with a single unload_done.
- Reset_n low at k=77:
  - Outputs go to 0 asynchronously; busy=0, no unload_done.
  - A new start afterwards restarts from k=0 with correct data.
